// File: rtl/oscill_pkg.sv
// Shared definitions for the oscilloscope trigger/capture block:
// FSM encoding, trigger-mode codes and the edge-match rule.
package oscill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] TRIG_RISE = 2'b00;
  localparam logic [1:0] TRIG_FALL = 2'b01;
  localparam logic [1:0] TRIG_BOTH = 2'b10;
  localparam logic [1:0] TRIG_AUTO = 2'b11;

  // prev_lo/cur_lo mean "sample below the level"; auto never matches on an edge
  function automatic logic edge_match(input logic [1:0] mode, input logic prev_lo,
                                      input logic cur_lo);
    logic rise;
    logic fall;
    rise = prev_lo && !cur_lo;
    fall = !prev_lo && cur_lo;
    case (mode)
      TRIG_RISE: edge_match = rise;
      TRIG_FALL: edge_match = fall;
      TRIG_BOTH: edge_match = rise || fall;
      default:   edge_match = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/oscill_edge_det.sv
// Trigger-channel mux plus previous-sample tracking; raises hit_o for an
// accepted sample that forms the selected edge against the trigger level.
module oscill_edge_det
  import oscill_pkg::*;
#(
  parameter int DW = 8,
  parameter int CH = 2,
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             smp_vld_i,
  input  logic [CH*DW-1:0] din_i,
  input  logic [CW-1:0]    ch_i,
  input  logic [1:0]       mode_i,
  input  logic [DW-1:0]    level_i,
  output logic             hit_o
);

  logic [DW-1:0] cur;
  logic [DW-1:0] prev_q;
  logic          prev_vld_q;

  // Out-of-range channel selects fall back to channel 0
  always_comb begin
    cur = din_i[DW-1:0];
    for (int k = 1; k < CH; k++) begin
      cur = (int'(ch_i) == k) ? din_i[k*DW +: DW] : cur;
    end
    hit_o = smp_vld_i && prev_vld_q &&
            edge_match(mode_i, (prev_q < level_i), (cur < level_i));
  end

  // Previous accepted sample; the first sample after a clear has no predecessor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (clr_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (smp_vld_i) begin
      prev_q     <= cur;
      prev_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/oscill_trig_capture.sv
// Circular-buffer capture controller: decimates the ADC stream, writes samples
// to RAM, and frames a record of pre_len pre-trigger and 2^AW-pre_len post samples.
module oscill_trig_capture
  import oscill_pkg::*;
#(
  parameter int DW = 8,
  parameter int CH = 2,
  parameter int AW = 10,
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adc_vld_i,
  input  logic [CH*DW-1:0] adc_din_i,
  input  logic             arm_i,
  input  logic             force_i,
  input  logic [CW-1:0]    trig_ch_i,
  input  logic [1:0]       trig_mode_i,
  input  logic [DW-1:0]    trig_level_i,
  input  logic [AW-1:0]    pre_len_i,
  input  logic [7:0]       decim_i,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_o,
  output logic [CH*DW-1:0] wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW-1:0]    start_addr_o,
  output logic [AW-1:0]    trig_addr_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_e           state_q;
  logic [CW-1:0]    ch_q;
  logic [1:0]       mode_q;
  logic [DW-1:0]    level_q;
  logic [AW-1:0]    pre_len_q;
  logic [7:0]       decim_q;
  logic [7:0]       dec_cnt_q, dec_cnt_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             force_q;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [CH*DW-1:0] wr_data_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    start_q;
  logic [AW-1:0]    trig_q;

  logic             accept;
  logic             edge_hit;
  logic             trig_fire;
  logic [AW:0]      post_len;

  oscill_edge_det #(.DW(DW), .CH(CH), .CW(CW)) u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (arm_i),
    .smp_vld_i (accept),
    .din_i     (adc_din_i),
    .ch_i      (ch_q),
    .mode_i    (mode_q),
    .level_i   (level_q),
    .hit_o     (edge_hit)
  );

  // Sample acceptance, trigger decision and counter increments
  always_comb begin
    dec_cnt_d = (dec_cnt_q == 8'd0) ? decim_q : dec_cnt_q - 8'd1;
    ptr_d     = ptr_q + AW'(1);
    cnt_d     = cnt_q + (AW+1)'(1);
    post_len  = DEPTH - {1'b0, pre_len_q};
    accept    = adc_vld_i && (dec_cnt_q == 8'd0) &&
                (state_q inside {ST_PRE, ST_ARMED, ST_POST});
    trig_fire = accept && (state_q == ST_ARMED) &&
                ((mode_q == TRIG_AUTO) || force_q || force_i || edge_hit);
  end

  // Capture FSM with registered RAM write port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      mode_q    <= 2'b00;
      level_q   <= '0;
      pre_len_q <= '0;
      decim_q   <= 8'd0;
      dec_cnt_q <= 8'd0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      force_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= '0;
      trig_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (adc_vld_i) dec_cnt_q <= dec_cnt_d;
      if (arm_i) begin
        ch_q      <= trig_ch_i;
        mode_q    <= trig_mode_i;
        level_q   <= trig_level_i;
        pre_len_q <= pre_len_i;
        decim_q   <= decim_i;
        dec_cnt_q <= 8'd0;
        ptr_q     <= '0;
        wr_addr_q <= '0;
        cnt_q     <= '0;
        force_q   <= 1'b0;
        done_q    <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= (pre_len_i == '0) ? ST_ARMED : ST_PRE;
      end else begin
        if (accept) begin
          wr_en_q   <= 1'b1;
          wr_data_q <= adc_din_i;
          wr_addr_q <= ptr_q;
          ptr_q     <= ptr_d;
        end
        case (state_q)
          ST_PRE: begin
            if (force_i) force_q <= 1'b1;
            if (accept) begin
              if (cnt_d == {1'b0, pre_len_q}) begin
                cnt_q   <= '0;
                state_q <= ST_ARMED;
              end else begin
                cnt_q <= cnt_d;
              end
            end
          end
          ST_ARMED: begin
            if (force_i) force_q <= 1'b1;
            if (trig_fire) begin
              trig_q  <= ptr_q;
              start_q <= ptr_q - pre_len_q;
              cnt_q   <= (AW+1)'(1);
              // A one-sample post window completes on the trigger sample itself
              if (post_len == (AW+1)'(1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (accept) begin
              if (cnt_d == post_len) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                cnt_q <= cnt_d;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign start_addr_o = start_q;
  assign trig_addr_o  = trig_q;

endmodule

// File: tb/tb_oscill_trig_capture.sv
// Scoreboard bench for oscill_trig_capture: a record-level model predicts the
// RAM writes and final status; a monitor pops and compares every write.
module tb_oscill_trig_capture;
  import oscill_pkg::*;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int AW = 4;
  localparam int CW = 3;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             adc_vld_i;
  logic [CH*DW-1:0] adc_din_i;
  logic             arm_i;
  logic             force_i;
  logic [CW-1:0]    trig_ch_i;
  logic [1:0]       trig_mode_i;
  logic [DW-1:0]    trig_level_i;
  logic [AW-1:0]    pre_len_i;
  logic [7:0]       decim_i;
  logic             wr_en_o;
  logic [AW-1:0]    wr_addr_o;
  logic [CH*DW-1:0] wr_data_o;
  logic             busy_o;
  logic             done_o;
  logic [AW-1:0]    start_addr_o;
  logic [AW-1:0]    trig_addr_o;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t        sb_q[$];
  logic        s_vld[$];
  logic [15:0] s_din[$];
  logic        s_frc[$];
  int          errors = 0;
  int          checks = 0;

  oscill_trig_capture #(.DW(DW), .CH(CH), .AW(AW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_vld_i    (adc_vld_i),
    .adc_din_i    (adc_din_i),
    .arm_i        (arm_i),
    .force_i      (force_i),
    .trig_ch_i    (trig_ch_i),
    .trig_mode_i  (trig_mode_i),
    .trig_level_i (trig_level_i),
    .pre_len_i    (pre_len_i),
    .decim_i      (decim_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .start_addr_o (start_addr_o),
    .trig_addr_o  (trig_addr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: every RAM write must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && wr_en_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write",
                 wr_addr_o, wr_data_o);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", int'(wr_addr_o), e.addr);
        chk("wr_data", int'(wr_data_o), e.data);
      end
    end
  end

  task automatic s_clear();
    s_vld.delete();
    s_din.delete();
    s_frc.delete();
  endtask

  task automatic s_push(input logic v, input logic [15:0] d, input logic f);
    s_vld.push_back(v);
    s_din.push_back(d);
    s_frc.push_back(f);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en_o), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr_o), 0);
    chk({tag, "_wr_data"}, int'(wr_data_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_start"}, int'(start_addr_o), 0);
    chk({tag, "_trig"}, int'(trig_addr_o), 0);
  endtask

  // Predict the record from the stimulus, arm the DUT, play the stimulus, check status
  task automatic run_test(input logic [2:0] ch, input logic [1:0] md, input logic [7:0] lv,
                          input logic [3:0] pl, input logic [7:0] dc);
    logic [15:0] acc[$];
    int nval, fcand, trig, post, last, nwr, sel, cur, prv, pli, lvi;
    bit hit, rise, fall, exp_done;
    exp_t e;
    pli = int'(pl);
    lvi = int'(lv);
    sel = (int'(ch) < CH) ? int'(ch) : 0;
    nval = 0;
    fcand = 1 << 30;
    for (int i = 0; i < s_vld.size(); i++) begin
      if (s_frc[i] && !s_vld[i]) begin
        if (((acc.size() > pli) ? acc.size() : pli) < fcand)
          fcand = (acc.size() > pli) ? acc.size() : pli;
      end
      if (s_vld[i]) begin
        if (nval % (int'(dc) + 1) == 0) acc.push_back(s_din[i]);
        nval++;
      end
    end
    trig = -1;
    for (int i = pli; i < acc.size(); i++) begin
      cur = int'((acc[i] >> (8 * sel)) & 16'h00FF);
      hit = (md == TRIG_AUTO) || (fcand <= i);
      if (i >= 1) begin
        prv  = int'((acc[i-1] >> (8 * sel)) & 16'h00FF);
        rise = (prv < lvi) && (cur >= lvi);
        fall = (prv >= lvi) && (cur < lvi);
        if ((md == TRIG_RISE && rise) || (md == TRIG_FALL && fall) ||
            (md == TRIG_BOTH && (rise || fall)))
          hit = 1'b1;
      end
      if (hit) begin
        trig = i;
        break;
      end
    end
    post = DEPTH - pli;
    last = (trig >= 0) ? trig + post - 1 : acc.size() - 1;
    nwr = (acc.size() < last + 1) ? acc.size() : last + 1;
    exp_done = (trig >= 0) && (last < acc.size());
    for (int j = 0; j < nwr; j++) begin
      e.addr = j % DEPTH;
      e.data = int'(acc[j]);
      sb_q.push_back(e);
    end

    @(negedge clk);
    adc_vld_i = 1'b0;
    force_i = 1'b0;
    arm_i = 1'b1;
    trig_ch_i = ch;
    trig_mode_i = md;
    trig_level_i = lv;
    pre_len_i = pl;
    decim_i = dc;
    @(negedge clk);
    arm_i = 1'b0;
    trig_ch_i = 3'($urandom);
    trig_mode_i = 2'($urandom);
    trig_level_i = 8'($urandom);
    pre_len_i = 4'($urandom);
    decim_i = 8'($urandom);
    chk("arm_busy", int'(busy_o), 1);
    chk("arm_done", int'(done_o), 0);
    chk("arm_wr_addr", int'(wr_addr_o), 0);
    for (int c = 0; c < s_vld.size(); c++) begin
      adc_vld_i = s_vld[c];
      adc_din_i = s_din[c];
      force_i = s_frc[c];
      @(negedge clk);
    end
    adc_vld_i = 1'b0;
    force_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("done", int'(done_o), int'(exp_done));
    chk("busy", int'(busy_o), int'(!exp_done));
    if (trig >= 0) begin
      chk("trig_addr", int'(trig_addr_o), trig % DEPTH);
      chk("start_addr", int'(start_addr_o), ((trig - pli) % DEPTH + DEPTH) % DEPTH);
    end
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    adc_vld_i = 1'b0;
    adc_din_i = '0;
    arm_i = 1'b0;
    force_i = 1'b0;
    trig_ch_i = '0;
    trig_mode_i = 2'b00;
    trig_level_i = '0;
    pre_len_i = '0;
    decim_i = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Wrapping ramp on channel 0: rising crossing of 0x80 after the pre window
    s_clear();
    for (int k = 0; k < 50; k++) s_push(1'b1, {8'($urandom), 8'(8'h70 + 8 * k)}, 1'b0);
    run_test(3'd0, TRIG_RISE, 8'h80, 4'd4, 8'd0);

    // Decimation by 3 with continuous strobes
    s_clear();
    for (int k = 0; k < 50; k++) s_push(1'b1, 16'($urandom), 1'b0);
    run_test(3'd1, TRIG_AUTO, 8'h00, 4'd3, 8'd2);

    // No pre window, auto trigger on the very first sample
    s_clear();
    for (int k = 0; k < 20; k++) s_push(1'b1, 16'($urandom), 1'b0);
    run_test(3'd0, TRIG_AUTO, 8'h00, 4'd0, 8'd0);

    // Flat signal: force in IDLE is ignored, force in PRE triggers at first ARMED sample
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force_i = 1'b1;
    @(negedge clk);
    force_i = 1'b0;
    s_clear();
    for (int k = 0; k < 30; k++) s_push(1'b1, 16'h2020, 1'b0);
    run_test(3'd7, TRIG_RISE, 8'h80, 4'd5, 8'd0);
    s_clear();
    for (int k = 0; k < 30; k++) s_push((k != 3), 16'h2020, (k == 3));
    run_test(3'd0, TRIG_RISE, 8'h80, 4'd5, 8'd0);

    // Trigger never arrives: write address wraps while busy stays high
    s_clear();
    for (int k = 0; k < 42; k++) s_push(1'b1, 16'h1010, 1'b0);
    run_test(3'd1, TRIG_FALL, 8'h80, 4'd2, 8'd0);

    // Leave a record mid-POST; the next arm must restart cleanly
    s_clear();
    for (int k = 0; k < 8; k++) s_push(1'b1, 16'($urandom), 1'b0);
    run_test(3'd0, TRIG_AUTO, 8'h00, 4'd2, 8'd0);

    for (int t = 0; t < 12; t++) begin
      s_clear();
      for (int c = 0; c < 120; c++) begin
        logic v;
        v = ($urandom_range(3) != 0);
        s_push(v, 16'($urandom), (!v && ($urandom_range(40) == 0)));
      end
      run_test(3'($urandom_range(7)), 2'($urandom_range(3)), 8'($urandom),
               4'($urandom_range(15)), 8'($urandom_range(3)));
    end

    // Asynchronous reset mid-POST clears everything and blocks further writes
    s_clear();
    for (int k = 0; k < 8; k++) s_push(1'b1, 16'($urandom), 1'b0);
    run_test(3'd0, TRIG_AUTO, 8'h00, 4'd2, 8'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("rst_mid_post");
    sb_q.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      adc_vld_i = 1'b1;
      adc_din_i = 16'($urandom);
      @(negedge clk);
    end
    adc_vld_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", int'(busy_o), 0);
    chk("post_rst_done", int'(done_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
